// File: rtl/plate_sequencer_mp.sv
// Multi-player plate sequencer: round-robin opcode arbitration, decode and
// dispatch to shared executors, per-player lose/score tracking, garbage routing.
//
// Ports:
//   clk_i, reset_i          clock, async active-high reset
//   opcode_i/opcode_v_i     per-player packed opcodes and valids
//   ready_o                 one-hot accept (IDLE only)
//   cm_empty_i              per-player tile memory empty
//   exe_op_o/exe_player_o   dispatched opcode and owner
//   exe_v_o/exe_done_i      executor start (held in EXEC) / completion pulse
//   lines_i/lines_v_i       line-elimination result (eCheck only)
//   stuck_i                 tile stuck outside game area (LOSTCHK)
//   lose_o/all_lost_o       sticky per-player lose, all-lost
//   score_o                 packed per-player saturating scores
//   garbage_o/_tgt_o/_v_o   garbage lines, target player, one-cycle pulse
//   timeout_o               sticky watchdog error
//   done_o/yumi_i           opcode finished / consumer ack

package plate_pkg;
  localparam int op_w = 4;
  typedef enum logic [op_w-1:0] {
    eNop       = 4'd0,
    eNew       = 4'd1,
    eMoveLeft  = 4'd2,
    eMoveRight = 4'd3,
    eMoveDown  = 4'd4,
    eRotate    = 4'd5,
    eCommit    = 4'd6,
    eCheck     = 4'd7
  } opcode_e;
endpackage

module plate_sequencer_mp
  import plate_pkg::*;
#(
  parameter int players_p     = 2,
  parameter int score_width_p = 16,
  parameter int timeout_p     = 255,
  localparam int pw = (players_p > 1) ? $clog2(players_p) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [players_p*op_w-1:0]          opcode_i,
  input  logic [players_p-1:0]               opcode_v_i,
  output logic [players_p-1:0]               ready_o,
  input  logic [players_p-1:0]               cm_empty_i,
  output logic [op_w-1:0]                    exe_op_o,
  output logic [pw-1:0]                      exe_player_o,
  output logic                               exe_v_o,
  input  logic                               exe_done_i,
  input  logic [2:0]                         lines_i,
  input  logic                               lines_v_i,
  input  logic                               stuck_i,
  output logic [players_p-1:0]               lose_o,
  output logic                               all_lost_o,
  output logic [players_p*score_width_p-1:0] score_o,
  output logic [2:0]                         garbage_o,
  output logic [pw-1:0]                      garbage_tgt_o,
  output logic                               garbage_v_o,
  output logic                               timeout_o,
  output logic                               done_o,
  input  logic                               yumi_i
);

  typedef logic [pw-1:0] idx_t;
  localparam int cnt_w = $clog2(timeout_p + 1);
  localparam int sw1   = score_width_p + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_NOP,
    S_LOSTCHK,
    S_DONE
  } state_e;

  state_e                   state_q;
  idx_t                     rr_q;
  idx_t                     cur_q;
  logic [op_w-1:0]          op_q;
  logic [cnt_w-1:0]         cnt_q;
  logic [score_width_p-1:0] score_q [players_p];

  logic            gnt_found;
  idx_t            gnt_idx;
  logic [op_w-1:0] gnt_op;
  idx_t            c_g;

  // Round-robin search starting just after the last granted player.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_op    = '0;
    c_g       = '0;
    for (int k = 1; k <= players_p; k++) begin
      c_g = idx_t'((int'(rr_q) + k) % players_p);
      if (!gnt_found && opcode_v_i[c_g] && !lose_o[c_g]) begin
        gnt_found = 1'b1;
        gnt_idx   = c_g;
        gnt_op    = opcode_i[int'(c_g)*op_w +: op_w];
      end
    end
  end

  always_comb begin
    ready_o = '0;
    for (int p = 0; p < players_p; p++) begin
      ready_o[p] = !reset_i && (state_q == S_IDLE) &&
                   gnt_found && (gnt_idx == idx_t'(p));
    end
  end

  // Next live player after the current one receives garbage.
  logic tgt_found;
  idx_t tgt_idx;
  idx_t c_t;

  always_comb begin
    tgt_found = 1'b0;
    tgt_idx   = '0;
    c_t       = '0;
    for (int k = 1; k < players_p; k++) begin
      c_t = idx_t'((int'(cur_q) + k) % players_p);
      if (!tgt_found && !lose_o[c_t]) begin
        tgt_found = 1'b1;
        tgt_idx   = c_t;
      end
    end
  end

  logic            dec_exec;
  logic [2:0]      lines_c;
  logic [3:0]      pts;
  logic [sw1-1:0]  sum;
  logic [score_width_p-1:0] new_score;
  logic            at_limit;
  logic            score_hit;

  always_comb begin
    unique case (op_q)
      eNew, eCheck:
        dec_exec = 1'b1;
      eMoveLeft, eMoveRight, eMoveDown, eRotate, eCommit:
        dec_exec = !cm_empty_i[cur_q];
      default:
        dec_exec = 1'b0;
    endcase
  end

  assign lines_c = (lines_i > 3'd4) ? 3'd4 : lines_i;

  always_comb begin
    unique case (lines_c)
      3'd1:    pts = 4'd1;
      3'd2:    pts = 4'd3;
      3'd3:    pts = 4'd5;
      3'd4:    pts = 4'd8;
      default: pts = 4'd0;
    endcase
  end

  assign sum       = {1'b0, score_q[cur_q]} + sw1'(pts);
  assign new_score = sum[score_width_p] ? '1 : sum[score_width_p-1:0];
  assign at_limit  = (cnt_q == cnt_w'(timeout_p - 1));

  // A result arriving on the watchdog cycle is dropped with the opcode.
  assign score_hit = (state_q == S_EXEC) && lines_v_i &&
                     (op_q == eCheck) && (exe_done_i || !at_limit);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      rr_q          <= idx_t'(players_p - 1);
      cur_q         <= '0;
      op_q          <= '0;
      cnt_q         <= '0;
      exe_v_o       <= 1'b0;
      done_o        <= 1'b0;
      timeout_o     <= 1'b0;
      lose_o        <= '0;
      garbage_o     <= '0;
      garbage_tgt_o <= '0;
      garbage_v_o   <= 1'b0;
      for (int p = 0; p < players_p; p++) begin
        score_q[p] <= '0;
      end
    end else begin
      garbage_v_o <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            op_q    <= gnt_op;
            cur_q   <= gnt_idx;
            rr_q    <= gnt_idx;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_exec) begin
            exe_v_o <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_EXEC;
          end else begin
            state_q <= S_NOP;
          end
        end
        S_EXEC: begin
          if (score_hit) begin
            score_q[cur_q] <= new_score;
            if (lines_c >= 3'd2 && tgt_found) begin
              garbage_v_o   <= 1'b1;
              garbage_o     <= lines_c - 3'd1;
              garbage_tgt_o <= tgt_idx;
            end
          end
          if (exe_done_i) begin
            exe_v_o <= 1'b0;
            if (op_q == eMoveDown) begin
              state_q <= S_LOSTCHK;
            end else begin
              done_o  <= 1'b1;
              state_q <= S_DONE;
            end
          end else if (at_limit) begin
            exe_v_o   <= 1'b0;
            timeout_o <= 1'b1;
            done_o    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_LOSTCHK: begin
          lose_o[cur_q] <= stuck_i;
          done_o        <= 1'b1;
          state_q       <= S_DONE;
        end
        S_NOP: begin
          done_o  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (yumi_i) begin
            done_o  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign exe_op_o     = op_q;
  assign exe_player_o = cur_q;
  assign all_lost_o   = &lose_o;

  always_comb begin
    score_o = '0;
    for (int p = 0; p < players_p; p++) begin
      score_o[p*score_width_p +: score_width_p] = score_q[p];
    end
  end

endmodule

// File: tb/tb_plate_sequencer_mp.sv
// Randomized bench for plate_sequencer_mp against a transaction-level model
// of arbitration, decode paths, latency, scoring, garbage and lose state.

module tb_plate_sequencer_mp;
  import plate_pkg::*;

  localparam int P  = 3;
  localparam int SW = 5;
  localparam int TO = 12;
  localparam int PW = 2;
  localparam int OW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [P*OW-1:0] opcode;
  logic [P-1:0]    opcode_v;
  logic [P-1:0]    ready;
  logic [P-1:0]    cm_empty;
  logic [OW-1:0]   exe_op;
  logic [PW-1:0]   exe_player;
  logic            exe_v;
  logic            exe_done;
  logic [2:0]      lines;
  logic            lines_v;
  logic            stuck;
  logic [P-1:0]    lose;
  logic            all_lost;
  logic [P*SW-1:0] score;
  logic [2:0]      garbage;
  logic [PW-1:0]   garbage_tgt;
  logic            garbage_v;
  logic            timeout;
  logic            done;
  logic            yumi;

  always #5 clk = ~clk;

  plate_sequencer_mp #(
    .players_p    (P),
    .score_width_p(SW),
    .timeout_p    (TO)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .opcode_i     (opcode),
    .opcode_v_i   (opcode_v),
    .ready_o      (ready),
    .cm_empty_i   (cm_empty),
    .exe_op_o     (exe_op),
    .exe_player_o (exe_player),
    .exe_v_o      (exe_v),
    .exe_done_i   (exe_done),
    .lines_i      (lines),
    .lines_v_i    (lines_v),
    .stuck_i      (stuck),
    .lose_o       (lose),
    .all_lost_o   (all_lost),
    .score_o      (score),
    .garbage_o    (garbage),
    .garbage_tgt_o(garbage_tgt),
    .garbage_v_o  (garbage_v),
    .timeout_o    (timeout),
    .done_o       (done),
    .yumi_i       (yumi)
  );

  int errs = 0;
  int checks = 0;

  int rr_m;
  bit lose_m [P];
  int score_m [P];
  bit to_m;
  int pts_m [5] = '{0, 1, 3, 5, 8};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [P*SW-1:0] score_vec();
    logic [P*SW-1:0] v;
    v = '0;
    for (int p = 0; p < P; p++) v[p*SW +: SW] = SW'(score_m[p]);
    return v;
  endfunction

  function automatic logic [P-1:0] lose_vec();
    logic [P-1:0] v;
    for (int p = 0; p < P; p++) v[p] = lose_m[p];
    return v;
  endfunction

  function automatic bit all_lost_m();
    bit a;
    a = 1'b1;
    for (int p = 0; p < P; p++) a &= lose_m[p];
    return a;
  endfunction

  task automatic idle_inputs();
    opcode   = '0;
    opcode_v = '0;
    cm_empty = '0;
    exe_done = 1'b0;
    lines    = '0;
    lines_v  = 1'b0;
    stuck    = 1'b0;
    yumi     = 1'b0;
  endtask

  // Entered and left on a falling edge.
  task automatic do_reset();
    reset    = 1'b1;
    opcode_v = '1;
    #2;
    chk("rst_ready", ready, '0);
    chk("rst_exe_v", exe_v, 0);
    chk("rst_done", done, 0);
    chk("rst_lose", lose, '0);
    chk("rst_score", score, '0);
    chk("rst_timeout", timeout, 0);
    chk("rst_garbage_v", garbage_v, 0);
    chk("rst_all_lost", all_lost, 0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    rr_m = P - 1;
    to_m = 1'b0;
    for (int p = 0; p < P; p++) begin
      lose_m[p]  = 1'b0;
      score_m[p] = 0;
    end
  endtask

  task automatic txn();
    logic [OW-1:0] ops [P];
    logic [OW-1:0] op;
    int  g, c, d, n, k, exv, lat, gt, lv, hold;
    bit  ex, tmo, gexp, seen;
    logic [2:0] gexp_l;

    for (int p = 0; p < P; p++) begin
      opcode_v[p] = 1'($urandom_range(0, 1));
      ops[p]      = OW'($urandom_range(0, 9));
      opcode[p*OW +: OW] = ops[p];
      cm_empty[p] = ($urandom_range(0, 3) == 0);
    end
    stuck = ($urandom_range(0, 4) == 0);
    #1;
    g = -1;
    for (int i = 1; i <= P; i++) begin
      c = (rr_m + i) % P;
      if (g < 0 && opcode_v[c] && !lose_m[c]) g = c;
    end
    chk("ready", ready, (g < 0) ? 0 : (1 << g));
    if (g < 0) begin
      @(negedge clk);
      opcode_v = '0;
      chk("no_grant_done", done, 0);
      return;
    end

    op  = ops[g];
    ex  = (op == eNew) || (op == eCheck) ||
          ((op >= eMoveLeft) && (op <= eCommit) && !cm_empty[g]);
    tmo = ex && ($urandom_range(0, 7) == 0);
    d   = $urandom_range(0, 4);
    lv  = $urandom_range(0, 7);
    lat = !ex ? 3 : tmo ? 2 + TO : 3 + d + ((op == eMoveDown) ? 1 : 0);

    gt = -1;
    for (int i = 1; i < P; i++) begin
      c = (g + i) % P;
      if (gt < 0 && !lose_m[c]) gt = c;
    end

    k = 0; exv = 0; gexp = 0; gexp_l = '0; seen = 0; n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n = i;
      opcode_v = '0;
      exe_done = 1'b0;
      lines_v  = 1'b0;
      yumi     = 1'($urandom_range(0, 1));
      chk("garbage_v", garbage_v, gexp);
      if (gexp) begin
        chk("garbage", garbage, gexp_l);
        chk("garbage_tgt", garbage_tgt, gt);
      end
      gexp = 0;
      if (done) begin
        seen = 1;
        break;
      end
      if (exe_v) begin
        exv++;
        if (k == 0) begin
          chk("exe_op", exe_op, op);
          chk("exe_player", exe_player, g);
        end
        if (k == 0 && !tmo) begin
          lines   = 3'(lv);
          lines_v = 1'b1;
          if (op == eCheck) begin
            c = (lv > 4) ? 4 : lv;
            score_m[g] += pts_m[c];
            if (score_m[g] > (1 << SW) - 1) score_m[g] = (1 << SW) - 1;
            gexp   = (c >= 2) && (gt >= 0);
            gexp_l = 3'(c - 1);
          end
        end
        if (!tmo && k == d) exe_done = 1'b1;
        k++;
      end
    end

    chk("done_seen", seen, 1);
    if (!seen) begin
      do_reset();
      return;
    end
    chk("latency", n, lat);
    chk("exe_v_cycles", exv, !ex ? 0 : tmo ? TO : d + 1);

    if (tmo) to_m = 1'b1;
    if (ex && !tmo && op == eMoveDown) lose_m[g] = stuck;
    rr_m = g;

    chk("lose", lose, lose_vec());
    chk("all_lost", all_lost, all_lost_m());
    chk("score", score, score_vec());
    chk("timeout", timeout, to_m);

    yumi = 1'b0;
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(negedge clk);
      chk("done_hold", done, 1);
    end
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
    chk("done_clear", done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    #1;
    do_reset();
    repeat (400) begin
      txn();
      if (all_lost_m() || $urandom_range(0, 80) == 0) do_reset();
    end

    // Reset while an opcode is executing.
    do_reset();
    opcode[OW-1:0] = eRotate;
    opcode_v       = 3'b001;
    cm_empty       = '0;
    for (int i = 0; i < 6 && !exe_v; i++) begin
      @(negedge clk);
      opcode_v = '0;
    end
    chk("reach_exec", exe_v, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_exe_v", exe_v, 0);
    chk("midrst_done", done, 0);
    chk("midrst_exe_op", exe_op, 0);
    chk("midrst_score", score, 0);
    chk("midrst_timeout", timeout, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
